lif_neuron_update: RTL and testbench

Combinational-plus-sequential membrane update stage of the LIF neuron datapath, sitting directly upstream of the previous-state register. Each cycle it takes the stored potential `prev_state` and the synaptic input `current`. It applies leak, integration, saturation and threshold comparison, and presents the next potential on `state` for the register to capture. It also owns the firing logic: the spike pulse, the refractory counter and the saturating spike counter.

---
 rtl/lif_neuron_update.sv | 58 +++++
 tb/tb_lif_neuron_update.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/lif_neuron_update.sv
// LIF membrane update: leak, integrate, saturate and threshold prev_state into state,
// plus the registered spike pulse, refractory counter and saturating spike counter.
module lif_neuron_update #(
  parameter int unsigned THRESHOLD     = 200,
  parameter int unsigned REST          = 0,
  parameter int unsigned LEAK_SHIFT    = 1,
  parameter int unsigned REFRAC_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [7:0] current,
  input  logic [7:0] prev_state,
  output logic [7:0] state,
  output logic       spike,
  output logic       refrac,
  output logic [7:0] spike_count
);

  localparam logic [7:0] THRESH_V = 8'(THRESHOLD);
  localparam logic [7:0] REST_V   = 8'(REST);
  localparam logic [7:0] REFRAC_V = 8'(REFRAC_CYCLES);

  logic [7:0] decayed;
  logic [8:0] sum;
  logic [7:0] sum_sat;
  logic [7:0] refrac_cnt;
  logic       fire;

  // Leak subtracts a shifted copy of itself, so it can never underflow.
  assign decayed = prev_state - (prev_state >> LEAK_SHIFT);
  assign sum     = {1'b0, decayed} + {1'b0, current};
  assign sum_sat = sum[8] ? 8'hFF : sum[7:0];
  assign refrac  = (refrac_cnt != 8'd0);
  assign fire    = en && reset_n && !refrac && (sum_sat >= THRESH_V);

  always_comb begin
    state = sum_sat;
    if (!reset_n)    state = REST_V;
    else if (!en)    state = prev_state;
    else if (refrac) state = REST_V;
    else if (fire)   state = REST_V;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      refrac_cnt  <= 8'd0;
      spike       <= 1'b0;
      spike_count <= 8'd0;
    end else begin
      spike <= fire;
      if (en && fire)        refrac_cnt <= REFRAC_V;
      else if (en && refrac) refrac_cnt <= refrac_cnt - 8'd1;
      if (fire && spike_count != 8'hFF) spike_count <= spike_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_lif_neuron_update.sv
// Directed bench for lif_neuron_update; the bench models the external previous-state
// register and also runs a zero-refractory instance for spike counter saturation.
module tb_lif_neuron_update;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic       loop_en;
  logic [7:0] current;
  logic [7:0] prev_drv;
  logic [7:0] prev_reg;
  logic [7:0] prev_state;
  logic [7:0] state, state0;
  logic       spike, spike0;
  logic       refrac, refrac0;
  logic [7:0] spike_count, spike_count0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) prev_reg <= state;
  assign prev_state = loop_en ? prev_reg : prev_drv;

  lif_neuron_update dut (
    .clk(clk), .reset_n(reset_n), .en(en), .current(current), .prev_state(prev_state),
    .state(state), .spike(spike), .refrac(refrac), .spike_count(spike_count)
  );

  lif_neuron_update #(.REFRAC_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .en(en), .current(current), .prev_state(prev_state),
    .state(state0), .spike(spike0), .refrac(refrac0), .spike_count(spike_count0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] loop_state [9]  = '{110, 165, 193, 0, 0, 0, 0, 0, 110};
  logic       loop_refrac [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
  logic       loop_spike [9]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
  logic [7:0] sub_state [8]   = '{60, 90, 105, 113, 117, 119, 120, 120};

  initial begin
    reset_n = 1'b0; en = 1'b1; loop_en = 1'b0; current = 8'd200; prev_drv = 8'd123;
    #1;
    chk("rst_state", state, 0);
    tick(); tick();
    chk("rst_spike", spike, 0);
    chk("rst_refrac", refrac, 0);
    chk("rst_count", spike_count, 0);

    // open-loop leak/integrate
    reset_n = 1'b1; prev_drv = 8'd100; current = 8'd50; #1;
    chk("int_100_50", state, 100);
    prev_drv = 8'd7; current = 8'd0; #1;
    chk("leak_7", state, 4);

    // saturation rather than wrap, then refractory with enable freeze
    prev_drv = 8'd254; current = 8'd200; #1;
    chk("sat_state", state, 0);
    tick();
    chk("sat_spike", spike, 1);
    chk("sat_refrac", refrac, 1);
    chk("sat_count", spike_count, 1);
    prev_drv = 8'd50; current = 8'd50; #1;
    chk("refrac_state", state, 0);
    tick();
    chk("spike_one_cycle", spike, 0);
    en = 1'b0; #1;
    chk("en_low_hold", state, 50);
    for (int i = 0; i < 3; i++) tick();
    chk("en_low_refrac", refrac, 1);
    chk("en_low_spike", spike, 0);
    chk("en_low_count", spike_count, 1);
    en = 1'b1;
    tick(); tick();
    chk("refrac_frozen", refrac, 1);
    tick();
    chk("refrac_end", refrac, 0);
    chk("resume_state", state, 75);

    // reset mid-refractory
    prev_drv = 8'd254; current = 8'd200;
    tick();
    chk("fire2_count", spike_count, 2);
    chk("fire2_refrac", refrac, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; prev_drv = 8'd100; current = 8'd50; #1;
    chk("midrst_refrac", refrac, 0);
    chk("midrst_count", spike_count, 0);
    chk("midrst_state", state, 100);

    // closed loop, current=110
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; loop_en = 1'b1; current = 8'd110;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk($sformatf("loop110_state[%0d]", i), state, loop_state[i]);
      chk($sformatf("loop110_refrac[%0d]", i), refrac, loop_refrac[i]);
      chk($sformatf("loop110_spike[%0d]", i), spike, loop_spike[i]);
      tick();
    end
    chk("loop110_count", spike_count, 1);

    // closed loop, sub-threshold current=60
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; current = 8'd60;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (i < 8) chk($sformatf("sub60_state[%0d]", i), state, sub_state[i]);
      else       chk($sformatf("sub60_le120[%0d]", i), state <= 8'd120, 1);
      chk($sformatf("sub60_spike[%0d]", i), spike, 0);
      tick();
    end
    chk("sub60_count", spike_count, 0);

    // zero refractory: fire every cycle, counter saturates at 255
    loop_en = 1'b0; reset_n = 1'b0;
    tick();
    reset_n = 1'b1; prev_drv = 8'd0; current = 8'd255;
    for (int k = 0; k < 300; k++) begin
      #1;
      chk($sformatf("cnt0_count[%0d]", k), spike_count0, (k > 255) ? 255 : k);
      chk($sformatf("cnt0_spike[%0d]", k), spike0, (k > 0) ? 1 : 0);
      if (k < 3) chk($sformatf("cnt0_state[%0d]", k), state0, 0);
      tick();
    end
    chk("cnt0_refrac", refrac0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
